// File: rtl/core_register_scoreboard_pkg.sv
// Shared constants and types for the multi-entry register hazard scoreboard.
// Entries are stored flat; the field constants below define the packing.
package core_scoreboard_pkg;

  localparam int L_PARAM_REG_W = 5;
  localparam int L_PARAM_PC_W  = 32;

  localparam logic [1:0] L_PARAM_SB_EMPTY  = 2'd0;
  localparam logic [1:0] L_PARAM_SB_ACTIVE = 2'd1;
  localparam logic [1:0] L_PARAM_SB_FULL   = 2'd2;

  // Entry layout: {valid, sysreg, reg[4:0], pc[31:0]}
  localparam int L_PARAM_ENT_PC_LSB     = 0;
  localparam int L_PARAM_ENT_REG_LSB    = L_PARAM_ENT_PC_LSB + L_PARAM_PC_W;
  localparam int L_PARAM_ENT_SYSREG_BIT = L_PARAM_ENT_REG_LSB + L_PARAM_REG_W;
  localparam int L_PARAM_ENT_VALID_BIT  = L_PARAM_ENT_SYSREG_BIT + 1;
  localparam int L_PARAM_ENT_W          = L_PARAM_ENT_VALID_BIT + 1;

  typedef struct packed {
    logic                     valid;
    logic                     sysreg;
    logic [L_PARAM_REG_W-1:0] regnum;
  } sb_operand_t;

  function automatic logic [1:0] sb_next_state(
    input logic [1:0] cur,
    input logic       nxt_zero,
    input logic       nxt_full
  );
    logic [1:0] nxt;
    nxt = cur;
    case (cur)
      L_PARAM_SB_EMPTY:  if (!nxt_zero) nxt = nxt_full ? L_PARAM_SB_FULL : L_PARAM_SB_ACTIVE;
      L_PARAM_SB_ACTIVE: begin
        if (nxt_full)      nxt = L_PARAM_SB_FULL;
        else if (nxt_zero) nxt = L_PARAM_SB_EMPTY;
      end
      L_PARAM_SB_FULL:   if (!nxt_full) nxt = nxt_zero ? L_PARAM_SB_EMPTY : L_PARAM_SB_ACTIVE;
      default:           nxt = L_PARAM_SB_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/core_register_scoreboard_if.sv
// Issue, writeback and status signals of the register scoreboard.
interface core_register_scoreboard_if
  import core_scoreboard_pkg::*;
#(
  parameter int P_DEPTH_N = 2
);

  logic                     iREFRESH;
  logic                     iISSUE_VALID;
  logic                     iISSUE_DEST_VALID;
  logic                     iISSUE_DEST_SYSREG;
  logic [L_PARAM_REG_W-1:0] iISSUE_DEST;
  logic                     iISSUE_SRC0_VALID;
  logic                     iISSUE_SRC0_SYSREG;
  logic [L_PARAM_REG_W-1:0] iISSUE_SRC0;
  logic                     iISSUE_SRC1_VALID;
  logic                     iISSUE_SRC1_SYSREG;
  logic [L_PARAM_REG_W-1:0] iISSUE_SRC1;
  logic [L_PARAM_PC_W-1:0]  iISSUE_PC;
  logic                     oISSUE_STALL;
  logic                     iWB_VALID;
  logic                     iWB_SYSREG;
  logic [L_PARAM_REG_W-1:0] iWB_REGISTER;
  logic [P_DEPTH_N:0]       oPENDING_COUNT;
  logic                     oEMPTY;
  logic                     oFULL;
  logic [L_PARAM_PC_W-1:0]  oOLDEST_PC;
  logic                     oERROR;

  modport slave (
    input  iREFRESH, iISSUE_VALID,
    input  iISSUE_DEST_VALID, iISSUE_DEST_SYSREG, iISSUE_DEST,
    input  iISSUE_SRC0_VALID, iISSUE_SRC0_SYSREG, iISSUE_SRC0,
    input  iISSUE_SRC1_VALID, iISSUE_SRC1_SYSREG, iISSUE_SRC1,
    input  iISSUE_PC,
    output oISSUE_STALL,
    input  iWB_VALID, iWB_SYSREG, iWB_REGISTER,
    output oPENDING_COUNT, oEMPTY, oFULL, oOLDEST_PC, oERROR
  );

  modport master (
    output iREFRESH, iISSUE_VALID,
    output iISSUE_DEST_VALID, iISSUE_DEST_SYSREG, iISSUE_DEST,
    output iISSUE_SRC0_VALID, iISSUE_SRC0_SYSREG, iISSUE_SRC0,
    output iISSUE_SRC1_VALID, iISSUE_SRC1_SYSREG, iISSUE_SRC1,
    output iISSUE_PC,
    input  oISSUE_STALL,
    output iWB_VALID, iWB_SYSREG, iWB_REGISTER,
    input  oPENDING_COUNT, oEMPTY, oFULL, oOLDEST_PC, oERROR
  );

endinterface

// File: rtl/core_register_scoreboard_match.sv
// Compares one issue operand against one in-flight scoreboard entry.
module core_scoreboard_match
  import core_scoreboard_pkg::*;
(
  input  sb_operand_t i_op,
  input  sb_operand_t i_ent,
  output logic        o_match
);

  assign o_match = i_op.valid & i_ent.valid &
                   (i_op.sysreg == i_ent.sysreg) &
                   (i_op.regnum == i_ent.regnum);

endmodule

// File: rtl/core_register_scoreboard.sv
// In-order queue of outstanding register writes; stalls issue on RAW/WAW
// hazards or when full, retires the head on writeback.
module core_register_scoreboard
  import core_scoreboard_pkg::*;
#(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
)(
  input logic                          iCLOCK,
  input logic                          iRESET,
  core_register_scoreboard_if.slave    bus
);

  localparam logic [P_DEPTH_N:0]   L_CNT_FULL = (P_DEPTH_N+1)'(P_DEPTH);
  localparam logic [P_DEPTH_N:0]   L_CNT_ONE  = (P_DEPTH_N+1)'(1);
  localparam logic [P_DEPTH_N-1:0] L_PTR_ONE  = P_DEPTH_N'(1);

  logic [L_PARAM_ENT_W-1:0] r_entry [P_DEPTH];
  logic [P_DEPTH_N-1:0]     r_wr_ptr;
  logic [P_DEPTH_N-1:0]     r_rd_ptr;
  logic [P_DEPTH_N:0]       r_count;
  logic [1:0]               r_state;
  logic                     r_error;

  logic [P_DEPTH_N:0]       w_count_nxt;
  logic [P_DEPTH-1:0]       w_src0_hit;
  logic [P_DEPTH-1:0]       w_src1_hit;
  logic [P_DEPTH-1:0]       w_dest_hit;
  sb_operand_t              w_op_src0;
  sb_operand_t              w_op_src1;
  sb_operand_t              w_op_dest;
  sb_operand_t              w_ent_op [P_DEPTH];
  logic                     w_hazard;
  logic                     w_full;
  logic                     w_stall;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_not_empty;
  logic                     w_wb_mismatch;
  logic                     w_err_set;
  logic                     w_head_sysreg;
  logic [L_PARAM_REG_W-1:0] w_head_reg;
  logic [L_PARAM_PC_W-1:0]  w_head_pc;

  assign w_op_src0 = {bus.iISSUE_SRC0_VALID, bus.iISSUE_SRC0_SYSREG, bus.iISSUE_SRC0};
  assign w_op_src1 = {bus.iISSUE_SRC1_VALID, bus.iISSUE_SRC1_SYSREG, bus.iISSUE_SRC1};
  assign w_op_dest = {bus.iISSUE_DEST_VALID, bus.iISSUE_DEST_SYSREG, bus.iISSUE_DEST};

  for (genvar gi = 0; gi < P_DEPTH; gi++) begin : g_ent
    assign w_ent_op[gi] = {r_entry[gi][L_PARAM_ENT_VALID_BIT],
                           r_entry[gi][L_PARAM_ENT_SYSREG_BIT],
                           r_entry[gi][L_PARAM_ENT_REG_LSB +: L_PARAM_REG_W]};

    core_scoreboard_match u_src0 (.i_op(w_op_src0), .i_ent(w_ent_op[gi]), .o_match(w_src0_hit[gi]));
    core_scoreboard_match u_src1 (.i_op(w_op_src1), .i_ent(w_ent_op[gi]), .o_match(w_src1_hit[gi]));
    core_scoreboard_match u_dest (.i_op(w_op_dest), .i_ent(w_ent_op[gi]), .o_match(w_dest_hit[gi]));
  end

  // Hazard and full come only from registered state: a same-cycle
  // writeback does not release the stall until the following cycle.
  assign w_hazard    = |{w_src0_hit, w_src1_hit, w_dest_hit};
  assign w_full      = (r_state == L_PARAM_SB_FULL);
  assign w_not_empty = (r_count != '0);
  assign w_stall     = bus.iISSUE_VALID & (w_hazard | w_full);
  assign w_push      = bus.iISSUE_VALID & ~w_stall & bus.iISSUE_DEST_VALID;
  assign w_pop       = bus.iWB_VALID & w_not_empty;

  assign w_head_sysreg = r_entry[r_rd_ptr][L_PARAM_ENT_SYSREG_BIT];
  assign w_head_reg    = r_entry[r_rd_ptr][L_PARAM_ENT_REG_LSB +: L_PARAM_REG_W];
  assign w_head_pc     = r_entry[r_rd_ptr][L_PARAM_ENT_PC_LSB +: L_PARAM_PC_W];

  assign w_wb_mismatch = {bus.iWB_SYSREG, bus.iWB_REGISTER} != {w_head_sysreg, w_head_reg};
  assign w_err_set     = bus.iWB_VALID & (~w_not_empty | w_wb_mismatch);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + L_CNT_ONE;
    else if (w_pop && !w_push) w_count_nxt = r_count - L_CNT_ONE;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      for (int i = 0; i < P_DEPTH; i++) r_entry[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= L_PARAM_SB_EMPTY;
      r_error  <= 1'b0;
    end else begin
      if (w_err_set) r_error <= 1'b1;

      if (bus.iREFRESH) begin
        for (int i = 0; i < P_DEPTH; i++) r_entry[i] <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_state  <= L_PARAM_SB_EMPTY;
      end else begin
        // Push and pop never target the same slot: that needs count 0 or full.
        if (w_pop) begin
          r_entry[r_rd_ptr][L_PARAM_ENT_VALID_BIT] <= 1'b0;
          r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
        end
        if (w_push) begin
          r_entry[r_wr_ptr] <= {1'b1, bus.iISSUE_DEST_SYSREG, bus.iISSUE_DEST, bus.iISSUE_PC};
          r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
        end
        r_count <= w_count_nxt;
        r_state <= sb_next_state(r_state, (w_count_nxt == '0), (w_count_nxt == L_CNT_FULL));
      end
    end
  end

  assign bus.oISSUE_STALL   = w_stall;
  assign bus.oPENDING_COUNT = r_count;
  assign bus.oEMPTY         = (r_state == L_PARAM_SB_EMPTY);
  assign bus.oFULL          = w_full;
  assign bus.oOLDEST_PC     = w_not_empty ? w_head_pc : '0;
  assign bus.oERROR         = r_error;

  a_count_range: assert property (@(posedge iCLOCK) disable iff (iRESET)
    r_count <= L_CNT_FULL);
  a_state_empty: assert property (@(posedge iCLOCK) disable iff (iRESET)
    (r_state == L_PARAM_SB_EMPTY) == (r_count == '0));
  a_state_full: assert property (@(posedge iCLOCK) disable iff (iRESET)
    (r_state == L_PARAM_SB_FULL) == (r_count == L_CNT_FULL));

endmodule

// File: tb/tb_core_register_scoreboard.sv
// Directed table-driven bench for core_register_scoreboard, plus a hand
// sequence for asynchronous reset in the middle of traffic.
module tb_core_register_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  core_register_scoreboard_if #(.P_DEPTH_N(2)) sb_if ();

  core_register_scoreboard #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
    .iCLOCK (clk),
    .iRESET (rst),
    .bus    (sb_if.slave)
  );

  typedef struct {
    logic        iv, dv, ds;
    logic [4:0]  d;
    logic        s0v, s0s;
    logic [4:0]  s0;
    logic        s1v, s1s;
    logic [4:0]  s1;
    logic [31:0] pc;
    logic        wbv, wbs;
    logic [4:0]  wbr;
    logic        rf;
    logic        e_stall;
    int          e_cnt;
    logic [31:0] e_pc;
    logic        e_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(
    input logic iv, dv, ds, input logic [4:0] d,
    input logic s0v, s0s, input logic [4:0] s0,
    input logic s1v, s1s, input logic [4:0] s1,
    input logic [31:0] pc,
    input logic wbv, wbs, input logic [4:0] wbr,
    input logic rf,
    input logic e_stall, input int e_cnt, input logic [31:0] e_pc, input logic e_err);
    vec_t r;
    r.iv = iv; r.dv = dv; r.ds = ds; r.d = d;
    r.s0v = s0v; r.s0s = s0s; r.s0 = s0;
    r.s1v = s1v; r.s1s = s1s; r.s1 = s1;
    r.pc = pc; r.wbv = wbv; r.wbs = wbs; r.wbr = wbr; r.rf = rf;
    r.e_stall = e_stall; r.e_cnt = e_cnt; r.e_pc = e_pc; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    sb_if.iREFRESH = 0; sb_if.iISSUE_VALID = 0;
    sb_if.iISSUE_DEST_VALID = 0; sb_if.iISSUE_DEST_SYSREG = 0; sb_if.iISSUE_DEST = '0;
    sb_if.iISSUE_SRC0_VALID = 0; sb_if.iISSUE_SRC0_SYSREG = 0; sb_if.iISSUE_SRC0 = '0;
    sb_if.iISSUE_SRC1_VALID = 0; sb_if.iISSUE_SRC1_SYSREG = 0; sb_if.iISSUE_SRC1 = '0;
    sb_if.iISSUE_PC = '0;
    sb_if.iWB_VALID = 0; sb_if.iWB_SYSREG = 0; sb_if.iWB_REGISTER = '0;
  endtask

  task automatic chk_status(input string tag, input int cnt, input logic [31:0] pc, input logic err);
    chk({tag, " count"},  32'(sb_if.oPENDING_COUNT), 32'(cnt));
    chk({tag, " empty"},  32'(sb_if.oEMPTY), 32'(cnt == 0));
    chk({tag, " full"},   32'(sb_if.oFULL),  32'(cnt == 4));
    chk({tag, " oldest"}, sb_if.oOLDEST_PC, pc);
    chk({tag, " error"},  32'(sb_if.oERROR), 32'(err));
  endtask

  // Called 1 time unit after a rising edge: drive, check stall, clock, check state.
  task automatic apply(input vec_t r, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    sb_if.iISSUE_VALID = r.iv;
    sb_if.iISSUE_DEST_VALID = r.dv; sb_if.iISSUE_DEST_SYSREG = r.ds; sb_if.iISSUE_DEST = r.d;
    sb_if.iISSUE_SRC0_VALID = r.s0v; sb_if.iISSUE_SRC0_SYSREG = r.s0s; sb_if.iISSUE_SRC0 = r.s0;
    sb_if.iISSUE_SRC1_VALID = r.s1v; sb_if.iISSUE_SRC1_SYSREG = r.s1s; sb_if.iISSUE_SRC1 = r.s1;
    sb_if.iISSUE_PC = r.pc;
    sb_if.iWB_VALID = r.wbv; sb_if.iWB_SYSREG = r.wbs; sb_if.iWB_REGISTER = r.wbr;
    sb_if.iREFRESH = r.rf;
    #3;
    chk({tag, " stall"}, 32'(sb_if.oISSUE_STALL), 32'(r.e_stall));
    @(posedge clk); #1;
    chk_status(tag, r.e_cnt, r.e_pc, r.e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    //            iv dv ds d      s0v s0s s0    s1v s1s s1    pc        wbv wbs wbr   rf  stall cnt pc     err
    // Basic RAW / sysreg distinction
    vt.push_back(v(1, 1, 0, 5'd3,  0, 0, 5'd0,  0, 0, 5'd0,  32'h100,  0, 0, 5'd0,  0,  0, 1, 32'h100, 0));
    vt.push_back(v(1, 0, 0, 5'd0,  1, 0, 5'd3,  0, 0, 5'd0,  32'h104,  0, 0, 5'd0,  0,  1, 1, 32'h100, 0));
    vt.push_back(v(1, 0, 0, 5'd0,  1, 1, 5'd3,  0, 0, 5'd3,  32'h108,  0, 0, 5'd0,  0,  0, 1, 32'h100, 0));
    vt.push_back(v(1, 0, 0, 5'd0,  0, 0, 5'd0,  1, 0, 5'd3,  32'h10C,  0, 0, 5'd0,  0,  1, 1, 32'h100, 0));
    vt.push_back(v(1, 1, 0, 5'd3,  0, 0, 5'd0,  0, 0, 5'd0,  32'h10C,  0, 0, 5'd0,  0,  1, 1, 32'h100, 0));
    vt.push_back(v(1, 1, 1, 5'd3,  0, 0, 5'd0,  0, 0, 5'd0,  32'h10C,  0, 0, 5'd0,  0,  0, 2, 32'h100, 0));
    vt.push_back(v(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0,  32'h0,    1, 0, 5'd3,  0,  0, 1, 32'h10C, 0));
    vt.push_back(v(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0,  32'h0,    1, 1, 5'd3,  0,  0, 0, 32'h0,   0));
    // Fill to full, stall through same-cycle writeback
    vt.push_back(v(1, 1, 0, 5'd1,  0, 0, 5'd0,  0, 0, 5'd0,  32'h200,  0, 0, 5'd0,  0,  0, 1, 32'h200, 0));
    vt.push_back(v(1, 1, 0, 5'd2,  0, 0, 5'd0,  0, 0, 5'd0,  32'h204,  0, 0, 5'd0,  0,  0, 2, 32'h200, 0));
    vt.push_back(v(1, 1, 0, 5'd3,  0, 0, 5'd0,  0, 0, 5'd0,  32'h208,  0, 0, 5'd0,  0,  0, 3, 32'h200, 0));
    vt.push_back(v(1, 1, 0, 5'd4,  0, 0, 5'd0,  0, 0, 5'd0,  32'h20C,  0, 0, 5'd0,  0,  0, 4, 32'h200, 0));
    vt.push_back(v(1, 1, 0, 5'd9,  0, 0, 5'd0,  0, 0, 5'd0,  32'h210,  0, 0, 5'd0,  0,  1, 4, 32'h200, 0));
    vt.push_back(v(1, 1, 0, 5'd9,  0, 0, 5'd0,  0, 0, 5'd0,  32'h210,  1, 0, 5'd1,  0,  1, 3, 32'h204, 0));
    vt.push_back(v(1, 1, 0, 5'd9,  0, 0, 5'd0,  0, 0, 5'd0,  32'h210,  0, 0, 5'd0,  0,  0, 4, 32'h204, 0));
    vt.push_back(v(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0,  32'h0,    1, 0, 5'd2,  0,  0, 3, 32'h208, 0));
    // RAW hazard not released by same-cycle writeback
    vt.push_back(v(1, 0, 0, 5'd0,  1, 0, 5'd3,  0, 0, 5'd0,  32'h214,  1, 0, 5'd3,  0,  1, 2, 32'h20C, 0));
    vt.push_back(v(1, 0, 0, 5'd0,  1, 0, 5'd3,  0, 0, 5'd0,  32'h214,  0, 0, 5'd0,  0,  0, 2, 32'h20C, 0));
    // Simultaneous push/pop at count 2, six cycles to wrap pointers
    vt.push_back(v(1, 1, 0, 5'd10, 0, 0, 5'd0,  0, 0, 5'd0,  32'h300,  1, 0, 5'd4,  0,  0, 2, 32'h210, 0));
    vt.push_back(v(1, 1, 0, 5'd11, 0, 0, 5'd0,  0, 0, 5'd0,  32'h304,  1, 0, 5'd9,  0,  0, 2, 32'h300, 0));
    vt.push_back(v(1, 1, 0, 5'd12, 0, 0, 5'd0,  0, 0, 5'd0,  32'h308,  1, 0, 5'd10, 0,  0, 2, 32'h304, 0));
    vt.push_back(v(1, 1, 0, 5'd13, 0, 0, 5'd0,  0, 0, 5'd0,  32'h30C,  1, 0, 5'd11, 0,  0, 2, 32'h308, 0));
    vt.push_back(v(1, 1, 0, 5'd14, 0, 0, 5'd0,  0, 0, 5'd0,  32'h310,  1, 0, 5'd12, 0,  0, 2, 32'h30C, 0));
    vt.push_back(v(1, 1, 0, 5'd15, 0, 0, 5'd0,  0, 0, 5'd0,  32'h314,  1, 0, 5'd13, 0,  0, 2, 32'h310, 0));
    // Protocol errors; refresh keeps the sticky error
    vt.push_back(v(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0,  32'h0,    1, 0, 5'd7,  0,  0, 1, 32'h314, 1));
    vt.push_back(v(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0,  32'h0,    1, 0, 5'd15, 0,  0, 0, 32'h0,   1));
    vt.push_back(v(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0,  32'h0,    1, 0, 5'd0,  0,  0, 0, 32'h0,   1));
    vt.push_back(v(1, 1, 0, 5'd1,  0, 0, 5'd0,  0, 0, 5'd0,  32'h400,  0, 0, 5'd0,  0,  0, 1, 32'h400, 1));
    vt.push_back(v(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0,  32'h0,    0, 0, 5'd0,  1,  0, 0, 32'h0,   1));
    // Refresh beats concurrent push and writeback at count 3
    vt.push_back(v(1, 1, 0, 5'd1,  0, 0, 5'd0,  0, 0, 5'd0,  32'h400,  0, 0, 5'd0,  0,  0, 1, 32'h400, 1));
    vt.push_back(v(1, 1, 0, 5'd2,  0, 0, 5'd0,  0, 0, 5'd0,  32'h404,  0, 0, 5'd0,  0,  0, 2, 32'h400, 1));
    vt.push_back(v(1, 1, 0, 5'd3,  0, 0, 5'd0,  0, 0, 5'd0,  32'h408,  0, 0, 5'd0,  0,  0, 3, 32'h400, 1));
    vt.push_back(v(1, 1, 0, 5'd20, 0, 0, 5'd0,  0, 0, 5'd0,  32'h40C,  1, 0, 5'd1,  1,  0, 0, 32'h0,   1));
    vt.push_back(v(1, 1, 0, 5'd3,  1, 0, 5'd2,  0, 0, 5'd0,  32'h500,  0, 0, 5'd0,  0,  0, 1, 32'h500, 1));
    vt.push_back(v(1, 1, 0, 5'd20, 0, 0, 5'd0,  0, 0, 5'd0,  32'h504,  0, 0, 5'd0,  0,  0, 2, 32'h500, 1));

    // Reset state, checked before the first clock edge
    rst = 1'b1;
    drive_idle();
    #2;
    chk_status("reset", 0, 32'h0, 1'b0);
    chk("reset stall idle", 32'(sb_if.oISSUE_STALL), 32'd0);
    sb_if.iISSUE_VALID = 1; sb_if.iISSUE_SRC0_VALID = 1; sb_if.iISSUE_SRC0 = 5'd3;
    #1;
    chk("reset stall issue", 32'(sb_if.oISSUE_STALL), 32'd0);
    drive_idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) apply(vt[i], i);

    // Mid-stream async reset at count 2 (r3, r20 in flight)
    drive_idle();
    sb_if.iISSUE_VALID = 1; sb_if.iISSUE_SRC0_VALID = 1; sb_if.iISSUE_SRC0 = 5'd3;
    #1;
    chk("pre-reset stall", 32'(sb_if.oISSUE_STALL), 32'd1);
    rst = 1'b1;
    #1;
    chk_status("async reset", 0, 32'h0, 1'b0);
    chk("async reset stall", 32'(sb_if.oISSUE_STALL), 32'd0);
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    apply(v(1, 1, 0, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0, 32'h600, 0, 0, 5'd0, 0, 0, 1, 32'h600, 0), 100);

    drive_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_register_scoreboard.md
Name: core_register_scoreboard

Overview:
- Multi-entry register hazard scheduler sitting between decode/issue and the writeback stage.
- Records the destination register (GPR or system register) of every issued, not-yet-written-back instruction in an in-order queue.
- Asserts an issue stall when a new instruction's sources or destination collide with any in-flight write, and retires entries in order on writeback.
- Extends the single-entry register hazard tracker to P_DEPTH outstanding writes.

Parameters:
- P_DEPTH, 4, number of outstanding writes tracked; power of two, ≥2.
- P_DEPTH_N, 2, log2(P_DEPTH); pointer width.

Ports:
- iCLOCK  in  1  core clock; all state updates on rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iREFRESH  in  1  synchronous flush (pipeline restart).
- iISSUE_VALID  in  1  issue request this cycle.
- iISSUE_DEST_VALID  in  1  instruction writes a register.
- iISSUE_DEST_SYSREG  in  1  destination is a system register.
- iISSUE_DEST  in  5  destination register number.
- iISSUE_SRC0_VALID / iISSUE_SRC0_SYSREG / iISSUE_SRC0  in  1/1/5  source operand 0.
- iISSUE_SRC1_VALID / iISSUE_SRC1_SYSREG / iISSUE_SRC1  in  1/1/5  source operand 1.
- iISSUE_PC  in  32  PC of the issuing instruction.
- oISSUE_STALL  out  1  issue must hold; combinational from stored state and current issue inputs.
- iWB_VALID  in  1  writeback of the oldest in-flight write.
- iWB_SYSREG  in  1  writeback target is a system register.
- iWB_REGISTER  in  5  writeback register number.
- oPENDING_COUNT  out  P_DEPTH_N+1  number of valid entries.
- oEMPTY  out  1  count == 0.
- oFULL  out  1  count == P_DEPTH.
- oOLDEST_PC  out  32  PC of the head entry; 0 when empty.
- oERROR  out  1  sticky protocol error flag.

Behaviour:
- Reset (iRESET high, async): all entries invalid; rd/wr pointers 0; count 0; oERROR 0. Outputs: oEMPTY=1, oFULL=0, oPENDING_COUNT=0, oOLDEST_PC=0, oISSUE_STALL=0.
- Entry contents: {valid, sysreg, reg[4:0], pc[31:0]}.
- Match rule: an operand matches an entry iff entry valid, operand valid, sysreg flags equal, and register numbers equal.
- Hazard conditions: SRC0 match (RAW), SRC1 match (RAW), or DEST match (WAW) against any valid entry.
- oISSUE_STALL = iISSUE_VALID & (hazard | oFULL).
- Writeback in the same cycle does NOT clear a hazard or full condition. No bypass; the stall drops the cycle after the retire.
- Accept: iISSUE_VALID & !oISSUE_STALL.
  - With iISSUE_DEST_VALID: push the entry at the write pointer the following edge.
  - Without it: nothing is stored; the instruction passes through.
- Retire: iWB_VALID with count > 0 pops the head entry.
  - If {iWB_SYSREG, iWB_REGISTER} differs from the head entry, set oERROR; the pop still occurs.
- iWB_VALID with count == 0: no state change except oERROR set.
- Simultaneous push and pop: both occur in the same cycle; count unchanged. Legal even when full, because the stall blocked any push while full.
- Pointers wrap modulo P_DEPTH. Count range is 0..P_DEPTH and never over- or underflows.
- iREFRESH: clears all entries, pointers and count on the next edge, and takes priority over push/pop in that cycle. oERROR is cleared only by iRESET.
- Occupancy FSM, derived from count:
  - EMPTY → ACTIVE on push.
  - ACTIVE → FULL when count reaches P_DEPTH.
  - FULL → ACTIVE on pop.
  - ACTIVE → EMPTY when count reaches 0.
  - Any state → EMPTY on iREFRESH or iRESET.
- Latency: a push is visible to hazard detection one cycle after acceptance; same for a pop.

Decomposition:
- Package core_scoreboard_pkg holds:
  - state encodings L_PARAM_SB_EMPTY / ACTIVE / FULL;
  - register-id width (5);
  - entry field layout constants.
- One natural sub-module: core_scoreboard_match, a combinational comparator of one operand {valid, sysreg, reg} against one entry, instantiated 3×P_DEPTH times.

Test Plan:
- Reset, then issue DEST=r3 (GPR) → next cycle oPENDING_COUNT=1, oOLDEST_PC=issue PC. Issue SRC0=r3 → oISSUE_STALL=1. Issue SRC0=sysreg 3 → oISSUE_STALL=0.
- Fill 4 entries r1..r4, then issue DEST=r9 → oFULL=1, oISSUE_STALL=1. WB r1 with a simultaneous issue → still stalled that cycle; the next cycle the issue is accepted and count stays 4.
- Push r5 while WB of head r1 in the same cycle at count 2 → count stays 2, head becomes the r5 entry's predecessor, pointers wrap correctly after 6 such cycles.
- WB r7 when head is r2 → oERROR=1, entry popped. WB with count 0 → oERROR stays 1, count stays 0. iREFRESH → count 0 but oERROR still 1.
- iREFRESH concurrent with push and WB at count 3 → next cycle count 0, oEMPTY=1, oOLDEST_PC=0.
- Assert iRESET mid-stream at count 2 → outputs return to reset values asynchronously, before the next edge; oERROR=0.
